// File: rtl/usr_sequencer_pkg.sv
// usr_sequencer shared definitions
// Opcode, datapath select and FSM state encodings.
package usr_sequencer_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_SHR  = 2'b01,
      OP_SHL  = 2'b10,
      OP_ROR  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      SEL_HOLD = 2'b00,
      SEL_SHR  = 2'b01,
      SEL_SHL  = 2'b10,
      SEL_LOAD = 2'b11
   } sel_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/usr_sequencer_if.sv
// usr_sequencer command handshake bundle
// Host drives the command; the sequencer answers with cmd_ready.
interface usr_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_count;
   logic [WIDTH-1:0] cmd_data;
   logic             cmd_fill;

   modport master (
      output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill,
      output cmd_ready
   );
endinterface

// File: rtl/usr_sequencer_usr.sv
// universal_shift_register: hold / shift right / shift left / load
// so_o captures the bit displaced by the latest shift.
module universal_shift_register
   import usr_sequencer_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  sel_e             sel_i,
   input  logic             right_i,
   input  logic             left_i,
   input  logic [WIDTH-1:0] par_i,
   output logic [WIDTH-1:0] q_o,
   output logic             so_o
);

   logic [WIDTH-1:0] q_q;
   logic             so_q;

   // Register update selected by the mode input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q  <= '0;
         so_q <= 1'b0;
      end else begin
         unique case (sel_i)
            SEL_HOLD: ;
            SEL_SHR: begin
               q_q  <= {right_i, q_q[WIDTH-1:1]};
               so_q <= q_q[0];
            end
            SEL_SHL: begin
               q_q  <= {q_q[WIDTH-2:0], left_i};
               so_q <= q_q[WIDTH-1];
            end
            SEL_LOAD: begin
               q_q  <= par_i;
               so_q <= 1'b0;
            end
         endcase
      end
   end

   assign q_o  = q_q;
   assign so_o = so_q;

endmodule

// File: rtl/usr_sequencer.sv
// usr_sequencer: command FSM driving a universal shift register
// One command at a time; done pulses one cycle after the last update.
module usr_sequencer
   import usr_sequencer_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             clr,
   usr_sequencer_if.slave   cmd,
   output logic [WIDTH-1:0] data_out,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   state_e           state_q;
   op_e              op_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] data_q;
   logic             fill_q;
   logic             done_q;

   sel_e             sel;
   logic             right_in;
   logic             left_in;

   // Command latch, remaining-count and state sequencing
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         op_q    <= OP_LOAD;
         cnt_q   <= '0;
         data_q  <= '0;
         fill_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (cmd.cmd_valid) begin
                  op_q   <= op_e'(cmd.cmd_op);
                  cnt_q  <= cmd.cmd_count;
                  data_q <= cmd.cmd_data;
                  fill_q <= cmd.cmd_fill;
                  if (op_e'(cmd.cmd_op) == OP_LOAD ||
                      cmd.cmd_count != '0) begin
                     state_q <= EXEC;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            EXEC: begin
               if (op_q != OP_LOAD) begin
                  cnt_q <= cnt_q - 1'b1;
               end
               if (op_q == OP_LOAD || cnt_q == 1) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Datapath mode and serial inputs for the current EXEC cycle
   always_comb begin
      sel      = SEL_HOLD;
      right_in = 1'b0;
      left_in  = 1'b0;
      if (state_q == EXEC) begin
         unique case (op_q)
            OP_LOAD: sel = SEL_LOAD;
            OP_SHR: begin
               sel      = SEL_SHR;
               right_in = fill_q;
            end
            OP_SHL: begin
               sel     = SEL_SHL;
               left_in = fill_q;
            end
            OP_ROR: begin
               sel      = SEL_SHR;
               right_in = data_out[0];
            end
         endcase
      end
   end

   universal_shift_register #(
      .WIDTH (WIDTH)
   ) u_usr (
      .clk     (clk),
      .rst_n   (clr),
      .sel_i   (sel),
      .right_i (right_in),
      .left_i  (left_in),
      .par_i   (data_q),
      .q_o     (data_out),
      .so_o    (serial_out)
   );

   assign cmd.cmd_ready = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign done          = done_q;

endmodule

// File: tb/tb_usr_sequencer.sv
// tb_usr_sequencer: scoreboard bench for usr_sequencer
// Each command pushes its per-cycle expected trace; the monitor pops it.
module tb_usr_sequencer;

   localparam int W = 4;
   localparam int C = 3;

   logic         clk = 1'b0;
   logic         clr;
   logic [W-1:0] data_out;
   logic         serial_out;
   logic         busy;
   logic         done;

   always #5 clk = ~clk;

   usr_sequencer_if #(.WIDTH(W), .CNT_W(C)) bus ();

   usr_sequencer #(
      .WIDTH (W),
      .CNT_W (C)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .cmd        (bus.slave),
      .data_out   (data_out),
      .serial_out (serial_out),
      .busy       (busy),
      .done       (done)
   );

   typedef struct packed {
      logic [W-1:0] d;
      logic         so;
      logic         dn;
      logic         bz;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] m_d;
   logic         m_so;
   int           checks = 0;
   int           errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: push the expected per-cycle trace of one command
   task automatic push_cmd(input logic [1:0] op, input int cnt,
                           input logic [W-1:0] dat, input logic fill);
      int n;
      n = (op == 2'b00) ? 1 : cnt;
      sb.push_back(exp_t'{m_d, m_so, (n == 0), 1'b1});
      for (int k = 1; k <= n; k++) begin
         case (op)
            2'b00: begin m_d = dat; m_so = 1'b0; end
            2'b01: begin m_so = m_d[0]; m_d = {fill, m_d[W-1:1]}; end
            2'b10: begin m_so = m_d[W-1]; m_d = {m_d[W-2:0], fill}; end
            default: begin m_so = m_d[0]; m_d = {m_d[0], m_d[W-1:1]}; end
         endcase
         sb.push_back(exp_t'{m_d, m_so, (k == n), 1'b1});
      end
      sb.push_back(exp_t'{m_d, m_so, 1'b0, 1'b0});
   endtask

   // Issue one command, then compare up to 'limit' trace entries
   task automatic send(input string tag, input logic [1:0] op,
                       input int cnt, input logic [W-1:0] dat,
                       input logic fill, input bit hold,
                       input int limit);
      int   waited;
      exp_t e;
      waited = 0;
      @(negedge clk);
      while (!bus.cmd_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_ready"}, bus.cmd_ready, 1'b1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_count = cnt[C-1:0];
      bus.cmd_data  = dat;
      bus.cmd_fill  = fill;
      push_cmd(op, cnt, dat, fill);
      for (int i = 0; i < limit && sb.size() > 0; i++) begin
         @(negedge clk);
         if (!hold) bus.cmd_valid = 1'b0;
         e = sb.pop_front();
         check({tag, "_data"}, data_out, e.d);
         check({tag, "_so"}, serial_out, e.so);
         check({tag, "_done"}, done, e.dn);
         check({tag, "_busy"}, busy, e.bz);
         check({tag, "_rdy"}, bus.cmd_ready, !e.bz);
      end
   endtask

   initial begin
      m_d           = '0;
      m_so          = 1'b0;
      clr           = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
      bus.cmd_count = '0;
      bus.cmd_data  = 4'b1111;
      bus.cmd_fill  = 1'b0;

      repeat (2) begin
         @(negedge clk);
         check("rst_data", data_out, 4'b0000);
         check("rst_done", done, 1'b0);
         check("rst_busy", busy, 1'b0);
         check("rst_so", serial_out, 1'b0);
      end
      bus.cmd_valid = 1'b0;
      clr = 1'b1;
      #1;
      check("rst_ready", bus.cmd_ready, 1'b1);

      send("load", 2'b00, 0, 4'b1011, 1'b0, 0, 100);
      send("shr", 2'b01, 2, 4'b0000, 1'b1, 0, 100);
      send("load2", 2'b00, 0, 4'b1011, 1'b0, 0, 100);
      send("shl", 2'b10, 3, 4'b0000, 1'b0, 0, 100);
      send("load3", 2'b00, 0, 4'b1011, 1'b0, 0, 100);
      send("ror", 2'b11, 4, 4'b0000, 1'b0, 0, 100);
      send("cnt0", 2'b01, 0, 4'b0000, 1'b1, 0, 100);
      send("load4", 2'b00, 0, 4'b1111, 1'b0, 0, 100);

      send("abort", 2'b10, 7, 4'b0000, 1'b0, 1, 3);
      check("abort_mid", data_out, 4'b1100);
      sb.delete();
      #2 clr = 1'b0;
      #1;
      check("abort_data", data_out, 4'b0000);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_so", serial_out, 1'b0);
      bus.cmd_valid = 1'b0;
      m_d  = '0;
      m_so = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("abort_nodone", done, 1'b0);
      end
      clr = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_done", done, 1'b0);
         check("post_ready", bus.cmd_ready, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/usr_sequencer.md
Name: usr_sequencer

Overview:
- Command-driven controller wrapped around a universal shift register datapath.
- Accepts one command at a time over a valid/ready handshake: parallel load, shift right, shift left or rotate right by N positions.
- Sequences the register's mode select and serial inputs cycle by cycle, then pulses done.
- Sits between a host or bus-side control block and the shift-register datapath, which it instantiates.

Parameters:
- WIDTH, 4, shift register width in bits (>=2).
- CNT_W, 3, width of the shift-count field; max count = 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous, active-low reset (clr=0 resets).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  operation: 00 load, 01 shift right, 10 shift left, 11 rotate right.
- cmd_count  input  CNT_W  number of shift positions; ignored for load.
- cmd_data  input  WIDTH  parallel load value; ignored for shifts.
- cmd_fill  input  1  serial fill bit for shift right/left; ignored for load/rotate.
- data_out  output  WIDTH  shift register contents.
- serial_out  output  1  bit shifted out by the most recent shift cycle.
- busy  output  1  command in progress (state != IDLE).
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (clr=0, async):
  - state=IDLE; data_out=0, serial_out=0, done=0, busy=0.
  - Remaining-count register = 0.
  - Effective immediately, including mid-command; the in-flight command is discarded.
- Datapath mode select (sel):
  - 00 hold.
  - 01 shift right: q <= {right_in, q[W-1:1]}.
  - 10 shift left: q <= {q[W-2:0], left_in}.
  - 11 parallel load.
- FSM states and transitions:
  - IDLE: cmd_ready=1, sel=00. On cmd_valid&cmd_ready, latch op/count/data/fill.
    - Load, or any shift with count>0 -> EXEC.
    - Shift/rotate with count=0 -> DONE; register untouched.
  - EXEC: cmd_ready=0.
    - Load: sel=11 for exactly one cycle, then DONE.
    - Shift right: sel=01, right_in=fill.
    - Shift left: sel=10, left_in=fill.
    - Rotate right: sel=01, right_in=q[0].
    - Remaining count decrements each cycle; on the cycle remaining==1, go to DONE.
  - DONE: sel=00, done=1 for exactly one cycle, then IDLE.
- cmd_ready is a combinational decode of state==IDLE. cmd_valid outside IDLE is ignored; there is no queuing.
- Latency (accept edge = T):
  - Load: data_out updates at T+1, done high in the cycle after T+1.
  - Shift by N: N updates at edges T+1..T+N, done high in the cycle after T+N.
  - Count 0: done high in the cycle after T.
- serial_out:
  - Each shift cycle registers the displaced bit: q[0] for right/rotate, q[W-1] for left.
  - Holds otherwise; cleared on load.
- Unused serial input is driven 0.
- busy = !IDLE.
- The count register is CNT_W bits; no wrap, because it only decrements from a nonzero value to 1.

Decomposition:
- Shared package:
  - op encoding constants OP_LOAD/OP_SHR/OP_SHL/OP_ROR.
  - sel encoding constants SEL_HOLD/SEL_SHR/SEL_SHL/SEL_LOAD.
  - FSM state constants IDLE/EXEC/DONE.
- One sub-module: universal_shift_register (existing datapath, WIDTH-parameterised), instantiated by usr_sequencer. The sequencer contains only the FSM, command latches and counter.

Test Plan (WIDTH=4, CNT_W=3):
- Reset: hold clr=0 for 2 cycles with cmd_valid=1 -> data_out=0000, done=0, busy=0, no command accepted; release, cmd_ready=1.
- Load: op=00, data=1011 -> data_out=1011 one cycle after accept; done pulses once the next cycle; busy returns 0.
- Shift right: from 1011, count=2, fill=1 -> 1101 then 1110; serial_out 1 then 1; done one cycle after 1110.
- Shift left: from 1011, count=3, fill=0 -> 0110, 1100, 1000; serial_out 1,0,1; done after 3rd update.
- Rotate right: from 1011, count=4 -> 1101, 1110, 0111, 1011; then count=0 command -> no change, done one cycle after accept.
- Abort/overlap:
  - Start shift left count=7 from 1111 and hold cmd_valid high throughout -> no second accept while busy.
  - Drop clr after 2 shifts -> data_out=0000 and busy=0 asynchronously; no done pulse.
